// File: rtl/rw_field.sv
// Multi-mode register field holding a WIDTH-bit value.
// Software and hardware can both access it, and MODE selects RW, RO, W1C, W1S or RC behaviour.
module rw_field #(
    parameter int WIDTH = 8,
    parameter int MODE  = 0
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [WIDTH-1:0] init,
    input  logic             read,
    input  logic             write,
    input  logic [WIDTH-1:0] wmask,
    input  logic [WIDTH-1:0] in,
    input  logic             hw_we,
    input  logic [WIDTH-1:0] hw_d,
    input  logic [WIDTH-1:0] hw_set,
    input  logic [WIDTH-1:0] ien,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] ro,
    output logic             chg,
    output logic             irq
);

    localparam int MODE_RW  = 0;
    localparam int MODE_RO  = 1;
    localparam int MODE_W1C = 2;
    localparam int MODE_W1S = 3;
    localparam int MODE_RC  = 4;

    if (MODE < MODE_RW || MODE > MODE_RC) begin : g_bad_mode
        $error("rw_field: unsupported MODE %0d", MODE);
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("rw_field: unsupported WIDTH %0d", WIDTH);
    end

    // There is no handshake. Each strobe qualifies only its own cycle, and holding a strobe high repeats its action.
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] hw_val;
    logic [WIDTH-1:0] d;

    assign sw     = write ? wmask : '0;
    assign hw_val = hw_we ? hw_d : q;

    always_comb begin
        d = q;
        case (MODE)
            MODE_RW:  d = (sw & in) | (~sw & hw_val);
            MODE_RO:  d = hw_val;
            MODE_W1C: d = (q & ~(sw & in)) | hw_set;
            MODE_W1S: d = hw_val | (sw & in);
            MODE_RC:  d = (read ? '0 : q) | hw_set;
            default:  d = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            q   <= init;
            chg <= 1'b0;
        end else begin
            q   <= d;
            chg <= (d != q);
        end
    end

    // In RC mode, ro returns the value held before the clear.
    assign ro  = read ? q : '0;
    assign irq = |(q & ien);

endmodule

// File: tb/tb_rw_field.sv
// Bench for rw_field. One instance per MODE is driven with shared stimulus.
// Every instance is compared against a bit-level behavioural model.
module tb_rw_field;

    localparam int W  = 8;
    localparam int NM = 5;

    logic         clk = 1'b0;
    logic         rstb;
    logic [W-1:0] init, wmask, in, hw_d, hw_set, ien;
    logic         read, write, hw_we;
    logic [W-1:0] q_o [NM];
    logic [W-1:0] ro_o[NM];
    logic         chg_o[NM];
    logic         irq_o[NM];

    logic [W-1:0] mq  [NM];
    logic         mchg[NM];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NM; g++) begin : g_dut
        rw_field #(.WIDTH(W), .MODE(g)) dut (
            .clk(clk), .rstb(rstb), .init(init), .read(read), .write(write),
            .wmask(wmask), .in(in), .hw_we(hw_we), .hw_d(hw_d), .hw_set(hw_set),
            .ien(ien), .q(q_o[g]), .ro(ro_o[g]), .chg(chg_o[g]), .irq(irq_o[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // The model applies each mode's rules one bit at a time.
    function automatic logic [W-1:0] model_next(input int m, input logic [W-1:0] cur);
        logic [W-1:0] nx;
        logic         s;
        for (int b = 0; b < W; b++) begin
            s = write && wmask[b];
            case (m)
                0: nx[b] = s ? in[b] : (hw_we ? hw_d[b] : cur[b]);
                1: nx[b] = hw_we ? hw_d[b] : cur[b];
                2: nx[b] = hw_set[b] ? 1'b1 : ((s && in[b]) ? 1'b0 : cur[b]);
                3: nx[b] = (s && in[b]) ? 1'b1 : (hw_we ? hw_d[b] : cur[b]);
                default: nx[b] = hw_set[b] ? 1'b1 : (read ? 1'b0 : cur[b]);
            endcase
        end
        return nx;
    endfunction

    task automatic idle_inputs();
        read = 0; write = 0; wmask = '0; in = '0; hw_we = 0; hw_d = '0; hw_set = '0; ien = '0;
    endtask

    // Checks the combinational outputs before the edge, then checks q and chg after it.
    task automatic tick();
        logic [W-1:0] nq[NM];
        logic         nc[NM];
        #1;
        for (int m = 0; m < NM; m++) begin
            check($sformatf("ro_m%0d", m), 32'(ro_o[m]), 32'(read ? mq[m] : '0));
            check($sformatf("irq_m%0d", m), 32'(irq_o[m]), 32'(|(mq[m] & ien)));
            if (!rstb) begin
                nq[m] = init;
                nc[m] = 0;
            end else begin
                nq[m] = model_next(m, mq[m]);
                nc[m] = (nq[m] != mq[m]);
            end
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < NM; m++) begin
            mq[m]   = nq[m];
            mchg[m] = nc[m];
            check($sformatf("q_m%0d", m), 32'(q_o[m]), 32'(mq[m]));
            check($sformatf("chg_m%0d", m), 32'(chg_o[m]), 32'(mchg[m]));
        end
    endtask

    task automatic do_reset(input logic [W-1:0] v);
        idle_inputs();
        rstb = 0;
        init = v;
        tick();
        tick();
        rstb = 1;
    endtask

    initial begin
        for (int m = 0; m < NM; m++) begin
            mq[m]   = 'x;
            mchg[m] = 'x;
        end
        rstb = 0;
        init = 8'hA5;
        idle_inputs();
        @(negedge clk);

        // Reset value, followed by a plain read.
        init = 8'hA5;
        rstb = 0;
        tick();
        tick();
        check("rst_q", 32'(q_o[0]), 32'h A5);
        check("rst_chg", 32'(chg_o[0]), 32'h0);
        check("rst_ro", 32'(ro_o[0]), 32'h0);
        check("rst_irq", 32'(irq_o[0]), 32'h0);
        rstb = 1;
        read = 1;
        #1;
        check("read_ro", 32'(ro_o[0]), 32'h A5);
        tick();
        read = 0;

        // RW masked write. Software has priority over a simultaneous hardware load.
        do_reset(8'hA5);
        write = 1; wmask = 8'h0F; in = 8'h3C; hw_we = 1; hw_d = 8'h00;
        tick();
        check("rw_q", 32'(q_o[0]), 32'h0C);
        check("rw_chg", 32'(chg_o[0]), 32'h1);
        idle_inputs();
        tick();
        check("rw_chg_drop", 32'(chg_o[0]), 32'h0);

        // W1C: set from hardware, then a set that competes with a clear.
        do_reset(8'h00);
        hw_set = 8'h81;
        tick();
        check("w1c_set", 32'(q_o[2]), 32'h81);
        hw_set = 8'h00; ien = 8'h01;
        #1;
        check("w1c_irq", 32'(irq_o[2]), 32'h1);
        write = 1; in = 8'h81; wmask = 8'hFF; hw_set = 8'h01;
        tick();
        check("w1c_clr", 32'(q_o[2]), 32'h01);

        // RC: ro returns the value from before the clear, and a concurrent event is kept.
        do_reset(8'h42);
        read = 1; hw_set = 8'h10;
        #1;
        check("rc_ro", 32'(ro_o[4]), 32'h42);
        tick();
        check("rc_q", 32'(q_o[4]), 32'h10);
        check("rc_chg", 32'(chg_o[4]), 32'h1);
        idle_inputs();
        tick();
        check("rc_chg_drop", 32'(chg_o[4]), 32'h0);

        // W1S: a software set is ORed with a hardware load. RO ignores software writes.
        do_reset(8'h00);
        write = 1; in = 8'h02; wmask = 8'hFF; hw_we = 1; hw_d = 8'h01;
        tick();
        check("w1s_q", 32'(q_o[3]), 32'h03);
        idle_inputs();
        tick();
        write = 1; in = 8'hFF; wmask = 8'hFF;
        tick();
        check("ro_hold", 32'(q_o[1]), 32'h01);
        check("ro_chg", 32'(chg_o[1]), 32'h0);

        // Asserting reset in the same cycle as a write overrides the write.
        idle_inputs();
        tick();
        rstb = 0; init = 8'h5A; write = 1; wmask = 8'hFF; in = 8'h3C;
        tick();
        check("mid_rst_q", 32'(q_o[0]), 32'h5A);
        check("mid_rst_chg", 32'(chg_o[0]), 32'h0);
        rstb = 1;
        idle_inputs();
        tick();
        check("post_rst_q", 32'(q_o[0]), 32'h5A);

        // Randomized traffic, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rstb   = ($urandom_range(0, 31) != 0);
            init   = W'($urandom);
            read   = $urandom_range(0, 2) == 0;
            write  = $urandom_range(0, 1) == 1;
            wmask  = W'($urandom);
            in     = W'($urandom);
            hw_we  = $urandom_range(0, 3) == 0;
            hw_d   = W'($urandom);
            hw_set = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
            ien    = W'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
